lc4_hazard_unit: RTL

- Control-side counterpart of the LC4 pipeline registers.
- Reads the decoded fields carried by the D/X, X/M and M/W pipeline registers and drives their hold/bubble/flush controls and the bypass mux selects.
- Carries a per-instruction stall code down the pipe to W for the trace/test harness.
- Keeps saturating stall and flush event counters.

---
 rtl/lc4_pipe_pkg.sv | 33 +++
 rtl/lc4_hazard_unit_if.sv | 42 ++++
 rtl/lc4_sat_counter.sv | 29 ++
 rtl/lc4_hazard_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/lc4_pipe_pkg.sv
// Shared types for the LC4 pipeline control: bypass selects, stall codes and
// the register-select width, plus the bypass priority helper.
package lc4_pipe_pkg;

  localparam int REG_SEL_W = 3;

  typedef logic [REG_SEL_W-1:0] reg_sel_t;

  typedef enum logic [1:0] {
    BYP_RF = 2'd0,
    BYP_MX = 2'd1,
    BYP_WX = 2'd2
  } byp_sel_e;

  typedef enum logic [1:0] {
    STALL_NONE  = 2'd0,
    STALL_FLUSH = 2'd2,
    STALL_LOAD  = 2'd3
  } stall_code_e;

  // M is the younger producer, so it wins over W when both match.
  function automatic byp_sel_e byp_select(input logic     re,
                                          input reg_sel_t sel,
                                          input logic     we_m,
                                          input reg_sel_t wsel_m,
                                          input logic     we_w,
                                          input reg_sel_t wsel_w);
    if (re && we_m && (wsel_m == sel)) return BYP_MX;
    if (re && we_w && (wsel_w == sel)) return BYP_WX;
    return BYP_RF;
  endfunction

endpackage

// File: rtl/lc4_hazard_unit_if.sv
// Decoded pipeline fields in, pipeline controls / bypass selects / trace out.
// master = pipeline datapath side, slave = hazard unit side. All signals are
// level-valued and sampled every cycle; there is no valid/ready handshake.
interface lc4_hazard_unit_if #(parameter int CNT_W = 16);
  import lc4_pipe_pkg::*;

  // D stage
  reg_sel_t r1sel_d, r2sel_d;
  logic     r1re_d, r2re_d, is_store_d, is_branch_d;
  // X stage
  reg_sel_t r1sel_x, r2sel_x, wsel_x;
  logic     r1re_x, r2re_x, regfile_we_x, is_load_x, taken_x;
  // M stage
  reg_sel_t r2sel_m, wsel_m;
  logic     regfile_we_m, is_store_m;
  // W stage
  reg_sel_t wsel_w;
  logic     regfile_we_w;
  // controls and trace
  logic             stall_f, bubble_x, flush_fd, flush_dx;
  logic [1:0]       rs_byp_sel, rt_byp_sel;
  logic             wm_byp_sel;
  logic [1:0]       stall_code_w;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output r1sel_d, r2sel_d, r1re_d, r2re_d, is_store_d, is_branch_d,
           r1sel_x, r2sel_x, wsel_x, r1re_x, r2re_x, regfile_we_x, is_load_x, taken_x,
           r2sel_m, wsel_m, regfile_we_m, is_store_m, wsel_w, regfile_we_w,
    input  stall_f, bubble_x, flush_fd, flush_dx, rs_byp_sel, rt_byp_sel,
           wm_byp_sel, stall_code_w, stall_cnt, flush_cnt
  );

  modport slave (
    input  r1sel_d, r2sel_d, r1re_d, r2re_d, is_store_d, is_branch_d,
           r1sel_x, r2sel_x, wsel_x, r1re_x, r2re_x, regfile_we_x, is_load_x, taken_x,
           r2sel_m, wsel_m, regfile_we_m, is_store_m, wsel_w, regfile_we_w,
    output stall_f, bubble_x, flush_fd, flush_dx, rs_byp_sel, rt_byp_sel,
           wm_byp_sel, stall_code_w, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/lc4_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; advances only
// on gwe cycles.
module lc4_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (gwe && inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lc4_hazard_unit.sv
// LC4 hazard unit: load-use stall, mispredict flush, bypass selects, a
// per-instruction stall code carried to W, and saturating event counters.
module lc4_hazard_unit
  import lc4_pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int FILL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            gwe,
  lc4_hazard_unit_if.slave hz
);

  localparam int FILL_W = (FILL_CYCLES < 2) ? 1 : $clog2(FILL_CYCLES + 1);

  logic lu, mp;

  stall_code_e       code_x_q, code_x_d, code_m_q, code_w_q;
  logic              flush_d_q;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Hazard detection: load in X feeding a D-stage reader (or NZP for a branch).
  always_comb begin
    lu = hz.is_load_x && hz.regfile_we_x &&
         ((hz.r1re_d && (hz.r1sel_d == hz.wsel_x)) ||
          (hz.r2re_d && !hz.is_store_d && (hz.r2sel_d == hz.wsel_x)) ||
          hz.is_branch_d);
    mp = hz.taken_x;
  end

  // A mispredict squashes both younger stages; a load-use stall is only
  // taken when no mispredict is in flight.
  assign hz.flush_fd = mp;
  assign hz.flush_dx = mp;
  assign hz.stall_f  = lu && !mp;
  assign hz.bubble_x = lu && !mp;

  assign hz.rs_byp_sel = byp_select(hz.r1re_x, hz.r1sel_x, hz.regfile_we_m, hz.wsel_m,
                                    hz.regfile_we_w, hz.wsel_w);
  assign hz.rt_byp_sel = byp_select(hz.r2re_x, hz.r2sel_x, hz.regfile_we_m, hz.wsel_m,
                                    hz.regfile_we_w, hz.wsel_w);
  assign hz.wm_byp_sel = hz.is_store_m && hz.regfile_we_w && (hz.wsel_w == hz.r2sel_m);

  // Code entering X: the slot squashed in F/D last cycle arrives as a flush.
  always_comb begin
    code_x_d = STALL_NONE;
    if (mp || flush_d_q) code_x_d = STALL_FLUSH;
    else if (lu)         code_x_d = STALL_LOAD;
  end

  // Fill counter counts down the empty slots that follow reset.
  always_comb begin
    fill_d = fill_q;
    if (fill_q != '0) fill_d = fill_q - FILL_W'(1);
  end

  // Stall-code pipe, flushed-D flag and fill counter; all hold while gwe=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_x_q  <= STALL_NONE;
      code_m_q  <= STALL_NONE;
      code_w_q  <= STALL_NONE;
      flush_d_q <= 1'b0;
      fill_q    <= FILL_W'(FILL_CYCLES);
    end else if (gwe) begin
      code_x_q  <= code_x_d;
      code_m_q  <= code_x_q;
      code_w_q  <= code_m_q;
      flush_d_q <= mp;
      fill_q    <= fill_d;
    end
  end

  assign hz.stall_code_w = (fill_q != '0) ? STALL_FLUSH : code_w_q;

  lc4_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .gwe   (gwe),
    .inc   (lu && !mp),
    .cnt_o (hz.stall_cnt)
  );

  lc4_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .gwe   (gwe),
    .inc   (mp),
    .cnt_o (hz.flush_cnt)
  );

endmodule
